// File: rtl/md_unit_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hi_wena;
    logic        lo_wena;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi_out, lo_out, hi_wena, lo_wena
    );
    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi_out, lo_out, hi_wena, lo_wena
    );
endinterface

// File: rtl/md_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit: operates on magnitudes for 32 steps,
// then applies sign correction in a single FIX cycle that writes HI/LO.
module md_unit #(
    parameter logic [31:0] DIV0_Q = 32'hFFFFFFFF,
    parameter int          ITER   = 32
) (
    input  logic     clk,
    input  logic     rst,
    md_unit_if.slave bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;

    logic          is_div, neg_res, neg_rem, div0;
    logic [31:0]   opa, opb;
    logic [63:0]   acc, acc_step, prod;
    logic [CW-1:0] cnt;
    logic          done_q;
    logic [31:0]   hi_q, lo_q;

    logic          sgn_in, div0_in;
    logic [31:0]   a_abs, b_abs;
    logic [32:0]   mul_sum, div_top, div_diff;
    logic [31:0]   quo, rem;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (cnt == CW'(ITER - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Signed ops use op[0]==0; divide-by-zero keeps the raw dividend so it can be returned in HI.
    assign sgn_in  = ~bus.op[0];
    assign div0_in = bus.op[1] && (bus.b == 32'd0);
    assign a_abs   = (sgn_in && bus.a[31] && !div0_in) ? (~bus.a + 32'd1) : bus.a;
    assign b_abs   = (sgn_in && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
    assign div_top  = acc[63:31];
    assign div_diff = div_top - {1'b0, opb};
    assign acc_step = !is_div    ? {mul_sum, acc[31:1]} :
                      div_diff[32] ? {acc[62:0], 1'b0} :
                                     {div_diff[31:0], acc[30:0], 1'b1};

    assign prod = neg_res ? (~acc + 64'd1) : acc;
    assign quo  = neg_res ? (~acc[31:0] + 32'd1)  : acc[31:0];
    assign rem  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= (state == FIX) && !bus.flush;
            case (state)
                IDLE: if (bus.start && !bus.flush) begin
                    is_div  <= bus.op[1];
                    neg_res <= sgn_in && !div0_in && (bus.a[31] ^ bus.b[31]);
                    neg_rem <= sgn_in && !div0_in && bus.op[1] && bus.a[31];
                    div0    <= div0_in;
                    opa     <= a_abs;
                    opb     <= b_abs;
                    acc     <= bus.op[1] ? {32'd0, a_abs} : {32'd0, b_abs};
                    cnt     <= '0;
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: if (!bus.flush) begin
                    if (div0) begin
                        hi_q <= opa;
                        lo_q <= DIV0_Q;
                    end else if (is_div) begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end else begin
                        hi_q <= prod[63:32];
                        lo_q <= prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.hi_wena = done_q;
    assign bus.lo_wena = done_q;
    assign bus.hi_out  = hi_q;
    assign bus.lo_out  = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: stimulus pushes expected HI/LO into a queue, a monitor pops on done.
module tb_md_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    md_unit_if bus();

    md_unit u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_hi = 32'd0, last_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.hi_wena !== bus.done || bus.lo_wena !== bus.done)
                chk("wena_eq_done", {30'd0, bus.hi_wena, bus.lo_wena}, {30'd0, bus.done, bus.done});
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("hi_out", bus.hi_out, e[63:32]);
                    chk("lo_out", bus.lo_out, e[31:0]);
                    last_hi = e[63:32];
                    last_lo = e[31:0];
                end
            end
        end
    end

    // Called at a negedge; leaves us at the negedge right after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done(input int exp_n, input string name);
        int  n = 0;
        bit  seen = 0;
        bit  busy_ok = 1;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen = 1;
            else if (bus.busy !== 1'b1) busy_ok = 0;
        end
        chk({name, "_latency"}, n, exp_n);
        chk({name, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        chk({name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input string name);
        exp_q.push_back({hi, lo});
        issue(op, a, b);
        wait_done(33, name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {30'd0, bus.done, bus.hi_wena}, 32'd0);
        chk("rst_hi",   bus.hi_out, 32'd0);
        chk("rst_lo",   bus.lo_out, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
        run(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        run(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negdiv");
        run(2'b11, 32'd7,        32'd2,        32'h00000001, 32'h00000003, "divu");
        run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");
        run(2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, "divu_zero");
        run(2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_zero");

        // A second start 5 cycles into a DIVU must be dropped.
        exp_q.push_back({32'd2, 32'd14});
        issue(2'b11, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(28, "start_ignored");

        // Flush 10 cycles after start: no result, outputs hold, next start accepted.
        issue(2'b01, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_done", {31'd0, bus.done}, 32'd0);
        chk("flush_hi_hold", bus.hi_out, last_hi);
        chk("flush_lo_hold", bus.lo_out, last_lo);
        run(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "after_flush");

        // Asynchronous reset mid-CALC clears outputs between edges.
        issue(2'b11, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst_hi",   bus.hi_out, 32'd0);
        chk("async_rst_lo",   bus.lo_out, 32'd0);
        chk("async_rst_done", {30'd0, bus.done, bus.lo_wena}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (45) @(negedge clk);
        chk("post_rst_idle", {31'd0, bus.busy}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
